// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register-index width,
// controller state encoding and the bundle of pipeline-register controls.
package mips_pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_hold;
    logic mem_wb_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_MEM_BUSY = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // $zero is never a real dependency: it reads as 0 regardless of the load.
  function automatic logic reg_hit(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, async clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, EX redirects,
// data-memory wait stalls with a sticky watchdog, plus stall/flush counters.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic             state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  pipe_state_e       r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;

  logic       w_load_use;
  logic       w_mem_busy;
  pipe_ctrl_t w_ctrl;

  assign w_load_use = ex_memread &&
                      (reg_hit(ex_rt, id_rs) || (id_uses_rt && reg_hit(ex_rt, id_rt)));
  assign w_mem_busy = mem_req && !mem_ready;

  // A stalled MEM stage freezes EX, so any redirect or load-use there simply
  // re-presents itself once memory completes; no deferral state is needed.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (reset) begin
      w_ctrl = CTRL_RESET;
    end else if (w_mem_busy) begin
      w_ctrl = CTRL_MEM_BUSY;
    end else if (ex_redirect) begin
      w_ctrl = CTRL_REDIRECT;
    end else if (w_load_use) begin
      w_ctrl = CTRL_LOAD_USE;
    end
  end

  assign pc_write      = w_ctrl.pc_write;
  assign if_id_write   = w_ctrl.if_id_write;
  assign if_id_flush   = w_ctrl.if_id_flush;
  assign id_ex_bubble  = w_ctrl.id_ex_bubble;
  assign ex_mem_hold   = w_ctrl.ex_mem_hold;
  assign mem_wb_bubble = w_ctrl.mem_wb_bubble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_wait_cnt <= '0;
          if (w_mem_busy) r_state <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (!w_mem_busy) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else begin
            if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt >= WAIT_LAST) r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign state       = r_state;
  assign mem_timeout = r_timeout;

  logic w_stall_inc;
  logic w_flush_inc;
  assign w_stall_inc = !w_ctrl.pc_write;
  assign w_flush_inc = w_ctrl.if_id_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush_inc),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle control
// vectors followed by hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_memread, ex_redirect, mem_req, mem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic             ex_mem_hold, mem_wb_bubble, state, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [5:0]       obs;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_memread    (ex_memread),
    .ex_rt         (ex_rt),
    .ex_redirect   (ex_redirect),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_hold   (ex_mem_hold),
    .mem_wb_bubble (mem_wb_bubble),
    .state         (state),
    .mem_timeout   (mem_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble}
  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble};

  typedef struct {
    string      name;
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rt;
    logic       redirect;
    logic       mreq;
    logic       mrdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic rd,
                       input logic rq, input logic ry);
    ex_memread  = mr;
    ex_rt       = ert;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = ur;
    ex_redirect = rd;
    mem_req     = rq;
    mem_ready   = ry;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, " rst ctrl"},    obs,         32'b001101);
    check({tag, " rst state"},   state,       32'd0);
    check({tag, " rst timeout"}, mem_timeout, 32'd0);
    check({tag, " rst stall"},   stall_cnt,   32'd0);
    check({tag, " rst flush"},   flush_cnt,   32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

  function automatic vec_t mk(input string nm, input logic mr, input logic [4:0] ert,
                              input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                              input logic rd, input logic rq, input logic ry,
                              input logic [5:0] e);
    vec_t v;
    v.name = nm; v.memread = mr; v.ex_rt = ert; v.id_rs = rs; v.id_rt = rt;
    v.uses_rt = ur; v.redirect = rd; v.mreq = rq; v.mrdy = ry; v.exp = e;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wait;

    vecs[0]  = mk("idle",             0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b110000);
    vecs[1]  = mk("loaduse rs",       1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, 6'b000100);
    vecs[2]  = mk("loaduse rt",       1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0, 6'b000100);
    vecs[3]  = mk("rt unused",        1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0, 6'b110000);
    vecs[4]  = mk("zero reg",         1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 6'b110000);
    vecs[5]  = mk("no memread",       0, 5'd8, 5'd8, 5'd8, 1, 0, 0, 0, 6'b110000);
    vecs[6]  = mk("redirect",         0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 6'b111100);
    vecs[7]  = mk("redirect+lu",      1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0, 6'b111100);
    vecs[8]  = mk("mem busy",         0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 6'b000011);
    vecs[9]  = mk("busy+redir+lu",    1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 0, 6'b000011);
    vecs[10] = mk("mem req ready",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 6'b110000);
    vecs[11] = mk("ready without req",0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 6'b110000);

    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_reset("initial");

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].memread, vecs[i].ex_rt, vecs[i].id_rs, vecs[i].id_rt,
            vecs[i].uses_rt, vecs[i].redirect, vecs[i].mreq, vecs[i].mrdy);
      #1;
      check(vecs[i].name, obs, vecs[i].exp);
    end

    // Single load-use cycle: one stall, one bubble.
    do_reset("loaduse");
    @(negedge clk);
    drive(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0);
    #1;
    check("lu pc_write", pc_write, 32'd0);
    check("lu bubble", id_ex_bubble, 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("lu released pc_write", pc_write, 32'd1);
    check("lu released bubble", id_ex_bubble, 32'd0);
    check("lu stall_cnt", stall_cnt, 32'd1);
    @(negedge clk);
    #1;
    check("lu stall_cnt hold", stall_cnt, 32'd1);

    // Load into $zero never stalls.
    do_reset("zero");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
      #1;
      check("zero pc_write", pc_write, 32'd1);
    end
    @(negedge clk);
    idle();
    #1;
    check("zero stall_cnt", stall_cnt, 32'd0);

    // Redirect wins over load-use.
    do_reset("redir_lu");
    @(negedge clk);
    drive(1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0);
    #1;
    check("rlu flush", if_id_flush, 32'd1);
    check("rlu pc_write", pc_write, 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("rlu flush_cnt", flush_cnt, 32'd1);
    check("rlu stall_cnt", stall_cnt, 32'd0);

    // Three busy cycles with a pending redirect; redirect lands in cycle 4.
    do_reset("memwait");
    n_wait = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 3)      drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
      else if (k == 4) drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1);
      else             idle();
      #1;
      if (state) n_wait++;
      if (k <= 3) begin
        check($sformatf("mw c%0d pc_write", k), pc_write, 32'd0);
        check($sformatf("mw c%0d flush", k), if_id_flush, 32'd0);
      end else if (k == 4) begin
        check("mw c4 flush", if_id_flush, 32'd1);
        check("mw c4 pc_write", pc_write, 32'd1);
        check("mw c4 state", state, 32'd1);
      end else begin
        check("mw c5 state", state, 32'd0);
      end
    end
    check("mw wait cycles", n_wait, 32'd3);
    check("mw stall_cnt", stall_cnt, 32'd3);
    check("mw flush_cnt", flush_cnt, 32'd1);

    // Watchdog: six busy cycles with TIMEOUT=4.
    do_reset("timeout");
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 6)      drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      else             idle();
      #1;
      check($sformatf("to c%0d timeout", k), mem_timeout, (k >= 6) ? 32'd1 : 32'd0);
      check($sformatf("to c%0d state", k), state, (k >= 2 && k <= 7) ? 32'd1 : 32'd0);
      if (k == 6) check("to c6 ctrl", obs, 32'b000011);
      if (k == 7) check("to c7 ctrl", obs, 32'b110000);
    end
    check("to stall_cnt", stall_cnt, 32'd6);
    do_reset("timeout clear");

    // Stall counter saturation, then reset in the middle of MEM_WAIT.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0);
      #1;
      check($sformatf("sat c%0d stall_cnt", k), stall_cnt, (k - 1 > 15) ? 32'd15 : 32'(k - 1));
    end
    @(negedge clk);
    idle();
    #1;
    check("sat final stall_cnt", stall_cnt, 32'd15);
    @(negedge clk);
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
    @(negedge clk);
    #1;
    check("midwait state", state, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midwait rst state", state, 32'd0);
    check("midwait rst stall", stall_cnt, 32'd0);
    check("midwait rst flush", flush_cnt, 32'd0);
    check("midwait rst ctrl", obs, 32'b001101);
    @(negedge clk);
    reset = 1'b0;
    idle();
    @(negedge clk);
    #1;
    check("post rst state", state, 32'd0);
    check("post rst stall", stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the MEM_WAIT cycle count that raises mem_timeout.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port id_rs / id_rt  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port id_uses_rt  input  1  ID instruction reads rt.
REQ-007 SHALL have port ex_memread / ex_rt  input  1 / 5  load in EX and its destination.
REQ-008 SHALL have port ex_redirect  input  1  taken branch or jump resolved in EX.
REQ-009 SHALL have port mem_req / mem_ready  input  1 each  data-memory access in MEM; access completes.
REQ-010 SHALL have port pc_write / if_id_write  output  1 each  PC and IF/ID load enables.
REQ-011 SHALL have port if_id_flush / id_ex_bubble / ex_mem_hold / mem_wb_bubble  output  1 each  pipeline register controls.
REQ-012 SHALL have port state  output  1  0=RUN, 1=MEM_WAIT.
REQ-013 SHALL have port mem_timeout  output  1  sticky watchdog flag.
REQ-014 SHALL have port stall_cnt / flush_cnt  output  CNT_W each  saturating performance counters.

Function
REQ-015 SHALL derive control outputs combinationally from registered state and current inputs (zero-cycle latency).
REQ-016 SHALL flag load-use when ex_memread=1, ex_rt!=0, and ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt).
REQ-017 SHALL flag mem_busy when mem_req=1 and mem_ready=0, in either state.
REQ-018 SHALL, on mem_busy, drive pc_write=0, if_id_write=0, ex_mem_hold=1, mem_wb_bubble=1, id_ex_bubble=0, if_id_flush=0; redirect and load-use are deferred.
REQ-019 SHALL otherwise, on ex_redirect=1, drive if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; redirect overrides load-use.
REQ-020 SHALL otherwise, on load-use, drive pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle.
REQ-021 SHALL otherwise drive pc_write=1, if_id_write=1 and all flush/bubble/hold outputs 0.
REQ-022 SHALL move RUN->MEM_WAIT on mem_busy, MEM_WAIT->RUN when mem_ready=1 or mem_req=0, and otherwise hold state.
REQ-023 SHALL count wait cycles in MEM_WAIT, clear the count on exit, and set mem_timeout when the count reaches TIMEOUT; mem_timeout stays set until reset and does not alter the controls.
REQ-024 SHALL increment stall_cnt once per cycle in which pc_write=0, saturating at all-ones.
REQ-025 SHALL increment flush_cnt once per cycle in which if_id_flush=1, saturating at all-ones.
REQ-026 SHALL apply a deferred redirect in the first cycle mem_busy=0; ex_redirect is still asserted then because EX was held.

Reset
REQ-027 SHALL, on reset assertion, immediately clear state to RUN, the wait count, mem_timeout, stall_cnt and flush_cnt to 0.
REQ-028 SHALL, while reset=1, force pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1, ex_mem_hold=0.
REQ-029 SHALL abandon any MEM_WAIT in progress on reset, with no counter update in that cycle.

Structure
REQ-030 SHALL take the state encoding, register-index width (5) and REG_ZERO constant from shared package mips_pipe_pkg.
REQ-031 SHALL instantiate sub-module sat_counter (parameter W, inputs clk, reset, inc; output q) twice, for stall_cnt and flush_cnt.

Verification
REQ-032 Load-use: ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_write=0 and id_ex_bubble=1 for 1 cycle; stall_cnt=1.
REQ-033 Zero register: ex_memread=1, ex_rt=0, id_rs=0 -> no stall; stall_cnt stays 0.
REQ-034 Redirect plus load-use in the same cycle -> if_id_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
REQ-035 mem_req=1 with mem_ready low 3 cycles, ex_redirect=1 throughout -> state=1 for 3 cycles, stall_cnt=3, flush in cycle 4, flush_cnt=1.
REQ-036 TIMEOUT=4, mem_ready held low 6 cycles -> mem_timeout=1 after the 4th wait cycle; remains 1 after exit; reset clears it.
REQ-037 CNT_W=4, 20 consecutive load-use cycles -> stall_cnt saturates at 15; reset mid-MEM_WAIT -> state=0 and counters 0 asynchronously.
